// File: rtl/matmul_apb_requester.sv
// matmul_apb_requester: valid/ready command stream to single APB transfers, one response per command.
// Optional ACCESS-phase timeout enabled by defining MATMUL_APB_TIMEOUT_EN.
module matmul_apb_requester #(
  parameter int DATA_WIDTH     = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]    cmd_wdata_i,
  input  logic [BUS_WIDTH/8-1:0]  cmd_strb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [BUS_WIDTH-1:0]    rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [BUS_WIDTH/8-1:0]  pstrb_o,
  output logic [BUS_WIDTH-1:0]    pwdata_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  input  logic [BUS_WIDTH-1:0]    prdata_i,
  input  logic                    busy_i,
  output logic                    busy_seen_o
);
  localparam int SW = BUS_WIDTH / 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2, S_RESP = 2'd3;
  if (BUS_WIDTH % 8 != 0 || DATA_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("matmul_apb_requester: illegal parameter set");
  end
  logic [1:0]            r_state;
  logic                  r_cmd_ready, r_rsp_valid, r_rsp_err, r_rsp_to;
  logic                  r_psel, r_penable, r_pwrite, r_busy_seen;
  logic [SW-1:0]         r_pstrb;
  logic [BUS_WIDTH-1:0]  r_pwdata, r_rsp_rdata;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  w_accept, w_misaligned, w_abort;
  assign w_accept     = (r_state == S_IDLE) && cmd_valid_i;
  assign w_misaligned = (cmd_addr_i & ADDR_WIDTH'(SW - 1)) != '0;
`ifdef MATMUL_APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  // Abort on the wait cycle that brings the count to the limit; pready in that cycle still wins.
  assign w_abort = (r_state == S_ACCESS) && !pready_i && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk_i) begin
    if (rst_i || w_accept) r_cnt <= '0;
    else if (r_state == S_ACCESS && !pready_i) r_cnt <= r_cnt + 1'b1;
  end
`else
  assign w_abort = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
      r_rsp_rdata <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pstrb     <= '0;
      r_pwdata    <= '0;
      r_paddr     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (cmd_valid_i) begin
          r_cmd_ready <= 1'b0;
          r_rsp_rdata <= '0;
          r_rsp_to    <= 1'b0;
          r_rsp_err   <= w_misaligned;
          if (w_misaligned) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_state  <= S_SETUP;
            r_psel   <= 1'b1;
            r_pwrite <= cmd_write_i;
            r_paddr  <= cmd_addr_i;
            r_pstrb  <= cmd_write_i ? cmd_strb_i : '0;
            r_pwdata <= cmd_write_i ? cmd_wdata_i : '0;
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
        end
        S_ACCESS: if (pready_i || w_abort) begin
          r_state     <= S_RESP;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= pready_i ? pslverr_i : 1'b1;
          r_rsp_to    <= !pready_i;
          r_rsp_rdata <= (pready_i && !r_pwrite) ? prdata_i : '0;
        end
        default: if (rsp_ready_i) begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) r_busy_seen <= 1'b0;
    else r_busy_seen <= w_accept ? busy_i : (r_busy_seen | busy_i);
  end
  assign cmd_ready_o   = r_cmd_ready;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_to;
  assign psel_o        = r_psel;
  assign penable_o     = r_penable;
  assign pwrite_o      = r_pwrite;
  assign pstrb_o       = r_pstrb;
  assign pwdata_o      = r_pwdata;
  assign paddr_o       = r_paddr;
  assign busy_seen_o   = r_busy_seen;
endmodule
